// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver with a small receive FIFO and a register read/write port.
//
// Parameters
//   DIVIDER : clocks per bit minus one (bit period = DIVIDER+1 clocks),
//             even and >= 4.
//   DEPTH   : receive FIFO entries, power of two, >= 2.
//
// Ports
//   clk      in   single clock, all state changes on its rising edge
//   rst_n    in   asynchronous active-low reset
//   addr     in   register select: 0 = RX data (pop), 1 = status, 2/3 = zero
//   rd_en    in   one-cycle read strobe
//   rd_data  out  registered read data, holds between reads
//   rd_valid out  one-cycle pulse, the cycle after rd_en
//   wr_en    in   one-cycle write strobe
//   wr_data  in   write data (addr 1: bit1 clears OVR, bit2 clears FERR)
//   rx       in   asynchronous serial line, idle high, LSB first
//
// Status byte: {4'b0, full, FERR, OVR, avail}
// ----------------------------------------------------------------------------
module uart_rx #(
    parameter int DIVIDER = 8,
    parameter int DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] addr,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rx
);

    localparam int TW = $clog2(DIVIDER + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // Receiver state
    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_sync1;
    logic            r_sync2;

    // FIFO and flags
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            r_ovr;
    logic            r_ferr;

    logic            w_rxs;
    logic            w_tick;
    logic            w_push;
    logic            w_ferr_set;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push_ok;
    logic            w_ovr_set;
    logic            w_flag_wr;
    logic [7:0]      w_status;
    logic            w_unused_wr;

    assign w_rxs      = r_sync2;
    assign w_tick     = (r_timer == '0);
    // Stop bit is sampled on the same edge that pushes or flags the frame.
    assign w_push     = (r_state == S_STOP) && w_tick && w_rxs;
    assign w_ferr_set = (r_state == S_STOP) && w_tick && !w_rxs;
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_COUNT);
    assign w_pop      = rd_en && (addr == 2'd0) && !w_empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO
    // still succeeds.
    assign w_push_ok  = w_push && (!w_full || w_pop);
    assign w_ovr_set  = w_push && w_full && !w_pop;
    assign w_flag_wr  = wr_en && (addr == 2'd1);
    assign w_status   = {4'b0000, w_full, r_ferr, r_ovr, !w_empty};
    assign w_unused_wr = ^{wr_data[7:3], wr_data[0]};

    // Two-flop synchronizer; resets to the idle-line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    // Receive FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rxs) begin
                        r_state <= S_START;
                        // Half a bit period lands the samples mid-bit.
                        r_timer <= TW'(DIVIDER / 2);
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (!w_rxs) begin
                            r_state   <= S_DATA;
                            r_timer   <= TW'(DIVIDER);
                            r_bit_cnt <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_shift[r_bit_cnt] <= w_rxs;
                        r_timer            <= TW'(DIVIDER);
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        r_state <= w_rxs ? S_IDLE : S_BREAK;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_BREAK: begin
                    if (w_rxs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO storage (no reset needed; occupancy is tracked by r_count)
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= r_shift;
        end
    end

    // FIFO pointers, count and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovr   <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Setting a flag wins over a same-cycle clear.
            if (w_ovr_set) begin
                r_ovr <= 1'b1;
            end else if (w_flag_wr && wr_data[1]) begin
                r_ovr <= 1'b0;
            end
            if (w_ferr_set) begin
                r_ferr <= 1'b1;
            end else if (w_flag_wr && wr_data[2]) begin
                r_ferr <= 1'b0;
            end
        end
    end

    // Registered read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                case (addr)
                    2'd0:    rd_data <= w_empty ? 8'h00 : r_mem[r_rptr];
                    2'd1:    rd_data <= w_status;
                    default: rd_data <= 8'h00;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx
// Drives serial frames, register reads and writes into uart_rx. A byte-level
// model (queue + two flags) predicts every read result; a compare process
// checks rd_valid/rd_data against the prediction on every clock, and also
// checks a few hand-computed literals requested by the stimulus thread.
// ----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int DIVIDER = 8;
    localparam int DEPTH   = 4;
    localparam int P       = DIVIDER + 1;

    logic       clk;
    logic       rst_n;
    logic [1:0] addr;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rx;

    uart_rx #(.DIVIDER(DIVIDER), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rx       (rx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model
    logic [7:0] q[$];
    logic       m_ovr;
    logic       m_ferr;

    // Expected read-port outputs (written by stimulus, read by comparator)
    logic       exp_rd_valid;
    logic [7:0] exp_rd_data;
    logic       rd_issued;
    logic [7:0] rd_next;

    // Literal check requests
    int         lit_req;
    int         lit_seen;
    logic [7:0] lit_exp;
    string      lit_name;

    int checks;
    int errors;

    function automatic logic [7:0] model_status();
        return {4'b0000, (q.size() == DEPTH), m_ferr, m_ovr, (q.size() != 0)};
    endfunction

    // Compare process: the only place counters are stepped.
    initial begin
        checks   = 0;
        errors   = 0;
        lit_seen = 0;
        forever begin
            @(negedge clk);
            checks++;
            if (rd_valid !== exp_rd_valid) begin
                errors++;
                $display("FAIL rd_valid: got %0b expected %0b at %0t", rd_valid, exp_rd_valid, $time);
            end
            checks++;
            if (rd_data !== exp_rd_data) begin
                errors++;
                $display("FAIL rd_data: got %02h expected %02h at %0t", rd_data, exp_rd_data, $time);
            end
            if (lit_req != lit_seen) begin
                lit_seen = lit_req;
                checks++;
                if (rd_data !== lit_exp) begin
                    errors++;
                    $display("FAIL %s: got %02h expected %02h at %0t", lit_name, rd_data, lit_exp, $time);
                end else begin
                    $display("check %s: rd_data %02h ok", lit_name, rd_data);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

    // Advance one clock; drive slot is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        exp_rd_valid = rd_issued;
        if (rd_issued) exp_rd_data = rd_next;
        rd_issued = 1'b0;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
    endtask

    task automatic issue_read(input logic [1:0] a);
        addr      = a;
        rd_en     = 1'b1;
        rd_issued = 1'b1;
        case (a)
            2'd0:    rd_next = (q.size() != 0) ? q.pop_front() : 8'h00;
            2'd1:    rd_next = model_status();
            default: rd_next = 8'h00;
        endcase
    endtask

    task automatic issue_write(input logic [1:0] a, input logic [7:0] d);
        addr    = a;
        wr_en   = 1'b1;
        wr_data = d;
        if (a == 2'd1) begin
            if (d[1]) m_ovr  = 1'b0;
            if (d[2]) m_ferr = 1'b0;
        end
    endtask

    task automatic do_read(input logic [1:0] a);
        issue_read(a);
        tick();
        $display("read  addr %0d -> expect %02h", a, rd_next);
    endtask

    task automatic do_write(input logic [1:0] a, input logic [7:0] d);
        issue_write(a, d);
        tick();
        $display("write addr %0d data %02h", a, d);
    endtask

    // Read, then pin the result to a hand-computed literal.
    task automatic read_lit(input logic [1:0] a, input logic [7:0] e, input string name);
        do_read(a);
        lit_exp  = e;
        lit_name = name;
        lit_req++;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int n, input logic rx_level);
        rx           = rx_level;
        rst_n        = 1'b0;
        rd_en        = 1'b0;
        wr_en        = 1'b0;
        rd_issued    = 1'b0;
        exp_rd_valid = 1'b0;
        exp_rd_data  = 8'h00;
        q.delete();
        m_ovr        = 1'b0;
        m_ferr       = 1'b0;
        repeat (n) tick();
        rst_n = 1'b1;
        $display("reset released, rx=%0b", rx_level);
    endtask

    task automatic gap(input int n);
        rx = 1'b1;
        repeat (n) tick();
    endtask

    // Serial frame; slot k is the k-th clock after the start bit is driven.
    // pop_k/clr_k place a strobe in that slot (sampled on the next edge),
    // abort_k pulses reset in that slot. Negative means unused.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int extra_low,
                              input int pop_k, input int clr_k, input logic [7:0] clr_d,
                              input int abort_k);
        logic [9:0] frame;
        frame = {stop_ok, b, 1'b0};
        for (int k = 0; k < 10 * P; k++) begin
            if (k == abort_k) begin
                $display("frame %02h aborted by reset at slot %0d", b, k);
                do_reset(3, 1'b1);
                gap(4);
                return;
            end
            rx = frame[k / P];
            if (k == pop_k) issue_read(2'd0);
            if (k == clr_k) issue_write(2'd1, clr_d);
            tick();
        end
        if (!stop_ok) begin
            rx = 1'b0;
            repeat (extra_low) tick();
        end
        if (stop_ok) begin
            if (q.size() < DEPTH) q.push_back(b);
            else m_ovr = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
        $display("frame %02h stop=%0b queued=%0d", b, stop_ok, q.size());
        gap(4);
    endtask

    task automatic glitch(input int len);
        rx = 1'b0;
        repeat (len) tick();
        $display("glitch %0d clocks", len);
        gap(12);
    endtask

    initial begin
        rx = 1'b1; addr = 2'd0; rd_en = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
        rd_issued = 1'b0; rd_next = 8'h00; exp_rd_valid = 1'b0; exp_rd_data = 8'h00;
        lit_req = 0; lit_exp = 8'h00; lit_name = "none";
        m_ovr = 1'b0; m_ferr = 1'b0;
        rst_n = 1'b1;
        #1;
        do_reset(4, 1'b1);
        gap(3);
        read_lit(2'd1, 8'h00, "reset_status");
        read_lit(2'd0, 8'h00, "reset_empty_read");

        // Single good frame
        send_frame(8'h55, 1'b1, 0, -1, -1, 8'h00, -1);
        read_lit(2'd1, 8'h01, "s55_status");
        read_lit(2'd0, 8'h55, "s55_data");
        read_lit(2'd1, 8'h00, "s55_status_after");

        // Framing error and clear
        send_frame(8'h00, 1'b0, 40, -1, -1, 8'h00, -1);
        read_lit(2'd1, 8'h04, "ferr_status");
        do_write(2'd1, 8'h04);
        read_lit(2'd1, 8'h00, "ferr_cleared");

        // Overrun
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0, -1, -1, 8'h00, -1);
        read_lit(2'd1, 8'h0B, "ovr_status");
        read_lit(2'd0, 8'h01, "ovr_rd1");
        read_lit(2'd0, 8'h02, "ovr_rd2");
        read_lit(2'd0, 8'h03, "ovr_rd3");
        read_lit(2'd0, 8'h04, "ovr_rd4");
        read_lit(2'd0, 8'h00, "ovr_rd_empty");
        read_lit(2'd1, 8'h02, "ovr_only");
        do_write(2'd1, 8'h02);
        read_lit(2'd1, 8'h00, "ovr_cleared");

        // Short glitch on idle line
        glitch(3);
        read_lit(2'd1, 8'h00, "glitch_status");
        read_lit(2'd0, 8'h00, "glitch_no_byte");

        // Pop on the stop-sample edge of a push into a full FIFO
        send_frame(8'h11, 1'b1, 0, -1, -1, 8'h00, -1);
        send_frame(8'h22, 1'b1, 0, -1, -1, 8'h00, -1);
        send_frame(8'h33, 1'b1, 0, -1, -1, 8'h00, -1);
        send_frame(8'h44, 1'b1, 0, -1, -1, 8'h00, -1);
        send_frame(8'hA5, 1'b1, 0, 10 * P - 2, -1, 8'h00, -1);
        read_lit(2'd1, 8'h09, "pushpop_status");
        read_lit(2'd0, 8'h22, "pushpop_rd1");
        read_lit(2'd0, 8'h33, "pushpop_rd2");
        read_lit(2'd0, 8'h44, "pushpop_rd3");
        read_lit(2'd0, 8'hA5, "pushpop_rd4");

        // FERR set and cleared on the same edge: set wins
        send_frame(8'h7E, 1'b0, 5, -1, 10 * P - 2, 8'h04, -1);
        read_lit(2'd1, 8'h04, "setclr_status");
        do_write(2'd1, 8'h06);
        read_lit(2'd1, 8'h00, "setclr_cleared");

        // Reset in the middle of data bit 4
        send_frame(8'h3C, 1'b1, 0, -1, -1, 8'h00, 5 * P + 4);
        read_lit(2'd1, 8'h00, "abort_status");
        read_lit(2'd0, 8'h00, "abort_empty");
        send_frame(8'h3C, 1'b1, 0, -1, -1, 8'h00, -1);
        read_lit(2'd0, 8'h3C, "abort_next_frame");

        // Reset released with the line held low
        do_reset(3, 1'b0);
        rx = 1'b0;
        repeat (150) tick();
        gap(10);
        m_ferr = 1'b1;
        read_lit(2'd1, 8'h04, "lowline_status");
        read_lit(2'd0, 8'h00, "lowline_no_byte");
        do_write(2'd1, 8'h04);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                send_frame(8'($urandom), ($urandom_range(0, 9) != 0), $urandom_range(0, 20),
                           -1, -1, 8'h00, -1);
            end else if (op <= 7) begin
                do_read(2'($urandom_range(0, 3)));
                do_read(2'($urandom_range(0, 1)));
            end else if (op == 8) begin
                do_write(2'($urandom_range(0, 3)), 8'($urandom));
            end else begin
                glitch($urandom_range(1, 4));
            end
            gap($urandom_range(0, 5));
        end
        while (q.size() != 0) do_read(2'd0);
        do_read(2'd1);
        gap(4);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DIVIDER, default 8, meaning clocks per bit minus one, so bit period P = DIVIDER+1 clocks; DIVIDER even, >= 4.
REQ-002 SHALL have parameter DEPTH, default 4, meaning receive FIFO entries; power of two.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port addr  input  2  register select.
REQ-006 SHALL have port rd_en  input  1  read strobe, one cycle.
REQ-007 SHALL have port rd_data  output  8  read data, registered.
REQ-008 SHALL have port rd_valid  output  1  one-cycle pulse marking rd_data valid.
REQ-009 SHALL have port wr_en  input  1  write strobe, one cycle.
REQ-010 SHALL have port wr_data  input  8  write data.
REQ-011 SHALL have port rx  input  1  serial line, asynchronous, idle high, 8N1 LSB first.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer, reset value 1; the FSM uses only the synchronized value rxs.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, BREAK, with an internal bit-timer and bit counter.
REQ-014 IDLE: on rxs==0 SHALL enter START with timer = DIVIDER/2.
REQ-015 START: timer decrements each clock; at timer==0, if rxs==0 enter DATA with timer=DIVIDER and bit count 0, else return to IDLE (glitch, no flag).
REQ-016 DATA: at timer==0 SHALL shift rxs into bit[count] (LSB first), reload timer=DIVIDER; after the 8th sample enter STOP.
REQ-017 STOP: at timer==0, if rxs==1 SHALL push the byte to the FIFO and enter IDLE; if rxs==0 SHALL set FERR, discard the byte, enter BREAK.
REQ-018 BREAK: SHALL remain until rxs==1, then enter IDLE.
REQ-019 Push when FIFO full (and no pop in same cycle) SHALL drop the new byte, keep FIFO contents, set OVR.
REQ-020 Read addr 0: SHALL return FIFO head and pop it; if empty, return 0x00 and leave state unchanged.
REQ-021 Read addr 1: SHALL return status {4'b0, full, FERR, OVR, avail}, avail = FIFO non-empty.
REQ-022 Reads of addr 2/3 SHALL return 0x00.
REQ-023 rd_valid SHALL pulse exactly one cycle, the cycle after any rd_en, with rd_data updated in the same edge; rd_data holds otherwise.
REQ-024 Write addr 1 SHALL clear OVR where wr_data[1]==1 and FERR where wr_data[2]==1; other writes ignored.
REQ-025 Simultaneous push and pop SHALL both complete; count unchanged; when full, the pop frees space so the push succeeds without OVR.
REQ-026 Simultaneous flag set (receiver) and clear (write) in one cycle SHALL leave the flag set.
REQ-027 FIFO pointers SHALL be log2(DEPTH) bits wrapping modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.
REQ-028 Byte availability latency: push occurs on the clock edge where the stop bit is sampled; avail visible in a status read issued the next cycle.

Reset
REQ-029 While rst_n==0: FSM=IDLE, timers/counters 0, FIFO empty, OVR=FERR=0, synchronizer=1, rd_data=0x00, rd_valid=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no push and no flag; after release a frame is only recognised from a new falling edge.
REQ-031 Release of rst_n while rx is low SHALL first pass through START glitch check; a held-low line yields at most FERR, never a data byte.

Verification
REQ-032 DIVIDER=8: send 0x55 at P=9 clocks, stop bit high -> status 0x01, read addr 0 -> rd_data 0x55, rd_valid one cycle, then status 0x00.
REQ-033 Send 0x00 with stop bit low, rx held low 40 clocks -> FERR set (status 0x04), no push; write addr 1 data 0x04 -> status 0x00.
REQ-034 Send 5 bytes 0x01..0x05 without reading -> status 0x0B (full, OVR, avail); reads return 0x01,0x02,0x03,0x04, then 0x00.
REQ-035 3-clock low glitch on idle rx -> returns to IDLE, status stays 0x00, no byte.
REQ-036 FIFO full; pop on the same cycle as stop-bit sample of 0xA5 -> OVR stays 0, 0xA5 read last after the three older bytes.
REQ-037 rst_n pulsed low at DATA bit 4 of 0x3C -> status 0x00 after release, FIFO empty; next clean frame 0x3C read correctly.
